// File: rtl/config_sram_loader.sv
// Serialises {data, addr} config records MSB-first into a downstream shift chain,
// then pulses config_set to commit each record; sticks in DONE after the last one.
module config_sram_loader #(
  parameter int ADDR_BITS  = 8,
  parameter int DATA_BITS  = 8,
  parameter int COUNT_BITS = 16
) (
  input  logic                  cclk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_BITS-1:0]  in_addr,
  input  logic [DATA_BITS-1:0]  in_data,
  input  logic                  in_last,
  output logic                  shift_enable,
  output logic                  shift_out,
  output logic                  config_set,
  output logic                  busy,
  output logic                  done,
  output logic [COUNT_BITS-1:0] record_count
);

  localparam int REC_LEN = ADDR_BITS + DATA_BITS;
  localparam int CNT_W   = $clog2(REC_LEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT,
    DONE
  } state_t;

  state_t               state, state_next;
  logic [REC_LEN-1:0]   shreg;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 last_q;
  logic                 accept;

  assign accept = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (bit_cnt == CNT_W'(1)) state_next = COMMIT;
      COMMIT:  state_next = last_q ? DONE : IDLE;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Fields are captured only on acceptance, so upstream may change them freely
  // while a record is in flight.
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      shreg        <= '0;
      bit_cnt      <= '0;
      last_q       <= 1'b0;
      record_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            shreg   <= {in_data, in_addr};
            bit_cnt <= CNT_W'(REC_LEN);
            last_q  <= in_last;
          end
        end
        SHIFT: begin
          shreg   <= {shreg[REC_LEN-2:0], 1'b0};
          bit_cnt <= bit_cnt - CNT_W'(1);
        end
        COMMIT: begin
          if (record_count != '1) record_count <= record_count + COUNT_BITS'(1);
        end
        default: ;
      endcase
    end
  end

  // in_ready is gated by rst so nothing is offered while reset is held.
  assign in_ready     = (state == IDLE) && !rst;
  assign shift_enable = (state == SHIFT);
  assign shift_out    = shift_enable & shreg[REC_LEN-1];
  assign config_set   = (state == COMMIT);
  assign busy         = (state == SHIFT) || (state == COMMIT);
  assign done         = (state == DONE);

endmodule

// File: tb/tb_config_sram_loader.sv
// Randomised self-checking bench for config_sram_loader; a second instance with
// COUNT_BITS=2 shares the stimulus to exercise counter saturation.
module tb_config_sram_loader;

  localparam int AB  = 8;
  localparam int DB  = 8;
  localparam int LEN = AB + DB;

  logic          cclk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [AB-1:0] in_addr = '0;
  logic [DB-1:0] in_data = '0;

  logic        in_ready, shift_enable, shift_out, config_set, busy, done;
  logic [15:0] record_count;
  logic        s_in_ready, s_shift_enable, s_shift_out, s_config_set, s_busy, s_done;
  logic [1:0]  s_record_count;

  config_sram_loader #(.ADDR_BITS(AB), .DATA_BITS(DB), .COUNT_BITS(16)) dut (
    .cclk(cclk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_last(in_last),
    .shift_enable(shift_enable), .shift_out(shift_out), .config_set(config_set),
    .busy(busy), .done(done), .record_count(record_count)
  );

  config_sram_loader #(.ADDR_BITS(AB), .DATA_BITS(DB), .COUNT_BITS(2)) dut_sat (
    .cclk(cclk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_last(in_last),
    .shift_enable(s_shift_enable), .shift_out(s_shift_out), .config_set(s_config_set),
    .busy(s_busy), .done(s_done), .record_count(s_record_count)
  );

  always #5 cclk = ~cclk;

  int unsigned cyc = 0;
  always @(posedge cclk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  int unsigned prev_acc = 0;
  bit have_prev = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected serial bit i: data MSB..LSB, then addr MSB..LSB.
  function automatic logic exp_bit(input logic [AB-1:0] a, input logic [DB-1:0] d, input int i);
    if (i < DB) return d[DB-1-i];
    return a[AB-1-(i-DB)];
  endfunction

  function automatic int sat(input int v, input int max_v);
    return (v > max_v) ? max_v : v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_shift_en"}, shift_enable, 1'b0);
    check({tag, "_shift_out"}, shift_out, 1'b0);
    check({tag, "_config_set"}, config_set, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_count"}, record_count, 0);
    check({tag, "_count_sat"}, s_record_count, 0);
  endtask

  // Called at a negedge. abort_at >= 0 asserts rst during that shift cycle.
  task automatic send_record(input logic [AB-1:0] a, input logic [DB-1:0] d, input logic last,
                             input bit hold, input bit toggle, input int abort_at);
    int waited = 0;
    while (!in_ready && waited < 40) begin
      @(negedge cclk);
      waited++;
    end
    check("ready_wait", in_ready, 1'b1);
    if (!in_ready) return;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_last  = last;
    if (hold && have_prev) check("b2b_interval", cyc - prev_acc, LEN + 2);
    prev_acc  = cyc;
    have_prev = 1;
    @(posedge cclk);
    #1;
    if (!hold) in_valid = 1'b0;
    for (int k = 0; k < LEN; k++) begin
      @(negedge cclk);
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        exp_count = 0;
        have_prev = 0;
        in_valid  = 1'b0;
        return;
      end
      check("shift_en", shift_enable, 1'b1);
      check($sformatf("shift_bit%0d", k), shift_out, exp_bit(a, d, k));
      check("shift_ready", in_ready, 1'b0);
      check("shift_busy", busy, 1'b1);
      check("shift_cfg", config_set, 1'b0);
      if (toggle) begin
        in_addr = AB'($urandom);
        in_data = DB'($urandom);
        in_last = 1'($urandom);
      end
    end
    @(negedge cclk);
    check("commit_cfg", config_set, 1'b1);
    check("commit_shift_en", shift_enable, 1'b0);
    check("commit_shift_out", shift_out, 1'b0);
    check("commit_busy", busy, 1'b1);
    check("commit_ready", in_ready, 1'b0);
    exp_count++;
    @(negedge cclk);
    check("count", record_count, sat(exp_count, 65535));
    check("count_sat", s_record_count, sat(exp_count, 3));
    check("post_done", done, last);
    check("post_ready", in_ready, !last);
    check("post_busy", busy, 1'b0);
    check("post_cfg", config_set, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge cclk);
    check_reset_outputs("reset");
    rst = 1'b0;
    #1;
    check("ready_after_reset", in_ready, 1'b1);
    @(negedge cclk);

    // Known vector: addr 0xA5, data 0x3C.
    send_record(8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, -1);

    // Back-to-back with in_valid held; the third is last.
    send_record(AB'($urandom), DB'($urandom), 1'b0, 1'b1, 1'b0, -1);
    send_record(AB'($urandom), DB'($urandom), 1'b1, 1'b1, 1'b0, -1);
    in_addr = AB'($urandom);
    in_data = DB'($urandom);
    for (int i = 0; i < 10; i++) begin
      @(negedge cclk);
      check("done_hold", done, 1'b1);
      check("done_ready", in_ready, 1'b0);
      check("done_shift", shift_enable, 1'b0);
      check("done_count", record_count, 3);
    end
    in_valid = 1'b0;

    // Reset leaves DONE; then abort a record on its 5th shift cycle.
    rst = 1'b1;
    @(negedge cclk);
    rst = 1'b0;
    #1;
    check("ready_after_done_reset", in_ready, 1'b1);
    send_record(AB'($urandom), DB'($urandom), 1'b0, 1'b0, 1'b0, 4);
    for (int i = 0; i < 3; i++) begin
      @(negedge cclk);
      check("abort_no_cfg", config_set, 1'b0);
    end
    rst = 1'b0;
    #1;
    check("ready_after_abort", in_ready, 1'b1);

    // Random records with inputs toggled during shifting.
    for (int r = 0; r < 8; r++)
      send_record(AB'($urandom), DB'($urandom), (r == 7), bit'(r % 2), 1'b1, -1);
    check("final_done_sat", s_done, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
